// File: rtl/femul.sv
// GF(2^255-19) multiplier: serial 17-bit-limb multiply, two carry-reduction passes, canonical result.
// Latency: done rises 48 cycles after the accepted start edge; one operation in flight at a time.
// Backpressure: start is ignored while busy; done and out hold until the next accepted start.
module femul (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);

    typedef enum logic [1:0] {IDLE, MUL, RED, FIN} state_t;

    state_t       state, state_nxt;
    logic [254:0] a_r, b_r;
    logic [43:0]  mid [15];
    logic [27:0]  carry;
    logic [3:0]   step;
    logic         pass;

    logic [16:0]  al [15];
    logic [16:0]  bj;
    logic [43:0]  mul_add [15];
    logic [43:0]  red_mid;
    logic [44:0]  red_sum;
    logic [255:0] v_sum, t_sum;
    logic [254:0] fin_res;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (step == 4'd14) state_nxt = RED;
            RED:     if (step == 4'd15 && pass) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bj = '0;
        for (int i = 0; i < 15; i++) begin
            al[i] = a_r[17*i +: 17];
            if (step == 4'(i)) bj = b_r[17*i +: 17];
        end
    end

    // Column k receives a_i*b_j with i = (k-j) mod 15; wrapped terms (k < j) carry the 2^255 = 19 fold.
    always_comb begin
        logic [3:0]  idx;
        logic [33:0] prod;
        idx  = '0;
        prod = '0;
        for (int k = 0; k < 15; k++) begin
            idx        = (4'(k) >= step) ? 4'(k) - step : 4'(k) + 4'd15 - step;
            prod       = 34'(al[idx]) * 34'(bj);
            mul_add[k] = (4'(k) < step) ? 44'(prod) * 44'd19 : 44'(prod);
        end
    end

    always_comb begin
        red_mid = (step == 4'd15) ? '0 : mid[step];
        red_sum = 45'(red_mid) + 45'(carry);
    end

    // After two passes the value is below 2p, so one conditional subtract of p (via +19) suffices.
    always_comb begin
        v_sum = '0;
        for (int k = 0; k < 15; k++)
            v_sum = v_sum + (256'(mid[k]) << (17*k));
        t_sum   = v_sum + 256'd19;
        fin_res = t_sum[255] ? t_sum[254:0] : v_sum[254:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= '0;
            step  <= '0;
            pass  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            for (int k = 0; k < 15; k++) mid[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= '0;
                        step  <= '0;
                        pass  <= 1'b0;
                        done  <= 1'b0;
                        for (int k = 0; k < 15; k++) mid[k] <= '0;
                    end
                end
                MUL: begin
                    for (int k = 0; k < 15; k++) mid[k] <= mid[k] + mul_add[k];
                    step <= (step == 4'd14) ? 4'd0 : step + 4'd1;
                end
                RED: begin
                    if (step == 4'd15) begin
                        mid[0] <= mid[0] + 44'(carry) * 44'd19;
                        carry  <= '0;
                        step   <= '0;
                        pass   <= ~pass;
                    end else begin
                        mid[step] <= 44'(red_sum[16:0]);
                        carry     <= red_sum[44:17];
                        step      <= step + 4'd1;
                    end
                end
                FIN: begin
                    out  <= fin_res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_femul.sv
// Randomised scoreboard bench for femul against a big-integer a*b mod p reference.
module tb_femul;

    localparam logic [255:0] P256 = (256'd1 << 255) - 256'd19;
    localparam logic [509:0] P510 = (510'd1 << 255) - 510'd19;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [254:0] a = '0;
    logic [254:0] b = '0;
    logic         done;
    logic [254:0] out;

    femul dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .done   (done),
        .out    (out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [254:0] res;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy = 0;
    int   accepted = 0;
    int   flushed = 0;
    int   completed = 0;
    logic done_q = 1'b0;
    logic [254:0] pm1;

    function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
        logic [509:0] pr;
        pr = 510'(x) * 510'(y);
        pr = pr % P510;
        return pr[254:0];
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r[254:0];
    endfunction

    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: an operation is accepted when start is seen while not busy, busy for 48 edges.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy = 0;
            flushed += q.size();
            q.delete();
        end else begin
            cyc++;
            if (busy != 0) begin
                busy--;
            end else if (start) begin
                q.push_back('{ref_mul(a, b), cyc});
                busy = 48;
                accepted++;
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (done && !done_q) begin
            completed++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: out=%h with nothing outstanding", out);
            end else begin
                e = q.pop_front();
                chk("product", out, e.res);
                checks++;
                if (cyc != e.cyc + 48) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected 48", cyc - e.cyc);
                end
                checks++;
                if (!(256'(out) < P256)) begin
                    errors++;
                    $display("FAIL canonical: out=%h not below p", out);
                end
            end
        end
        done_q = done;
    end

    task automatic wait_done(input string tag);
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (done) break;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout_%s: done=%b expected 1 within 60 cycles", tag, done);
        end
    endtask

    task automatic do_op(input logic [254:0] x, input logic [254:0] y, input string tag);
        @(negedge clock);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = rand255();
        b = rand255();
        wait_done(tag);
    endtask

    task automatic reset_mid(input int n);
        @(negedge clock);
        a = rand255();
        b = rand255();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (n - 1) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_done", 255'(done), 255'd0);
        chk("reset_mid_out", out, '0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        pm1 = P256[254:0] - 255'd1;
        repeat (3) @(negedge clock);
        chk("reset_done", 255'(done), 255'd0);
        chk("reset_out", out, '0);
        reset_n = 1'b1;

        do_op(255'd3, 255'd4, "small");
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("hold_done", 255'(done), 255'd1);
            chk("hold_out", out, 255'd12);
        end

        do_op(pm1, pm1, "pm1_sq");
        do_op(255'd1 << 254, 255'd2, "two255");
        do_op(255'd0, '1, "zero");
        do_op(P256[254:0], 255'd5, "p_times5");
        do_op('1, 255'd1, "max_times1");
        do_op('1, '1, "max_sq");

        // Stray start pulses while busy must not disturb the operation.
        @(negedge clock);
        a = rand255();
        b = rand255();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        a = rand255();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        b = rand255();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("midpulse");

        // Start held high: operands change every cycle, each completion chains into the next.
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = rand255();
            b = rand255();
            @(negedge clock);
        end
        start = 1'b0;
        repeat (60) @(negedge clock);

        reset_mid(7);
        do_op(rand255(), rand255(), "after_rst_mul");
        reset_mid(30);
        do_op(rand255(), rand255(), "after_rst_red");

        for (int i = 0; i < 1000; i++) do_op(rand255(), rand255(), "random");

        repeat (5) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drained: %0d outstanding expected 0", q.size());
        end
        checks++;
        if (completed != accepted - flushed) begin
            errors++;
            $display("FAIL completions: got %0d expected %0d", completed, accepted - flushed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
